// File: rtl/cdb_pkg.sv
// cdb_pkg: shared widths and the result packet carried by every CDB channel.
package cdb_pkg;
    localparam int DATA_W    = 64;
    localparam int PRF_SIZE  = 64;
    localparam int ROB_SIZE  = 32;
    localparam int TAG_W     = $clog2(PRF_SIZE);
    localparam int ROB_IDX_W = $clog2(ROB_SIZE) + 1;
    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [DATA_W-1:0]    data;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic                 branch_taken;
    } cdb_pkt_t;
endpackage

// File: rtl/cdb_rr_arbiter_if.sv
// cdb_rr_arbiter_if: FU result channels, squash request and CDB broadcast buses.
interface cdb_rr_arbiter_if #(parameter int NUM_FU = 6, parameter int NUM_CDB = 2);
    import cdb_pkg::*;
    logic [NUM_FU-1:0]                fu_valid;
    logic [NUM_FU-1:0]                fu_ready;
    logic [NUM_FU-1:0][DATA_W-1:0]    fu_result;
    logic [NUM_FU-1:0][TAG_W-1:0]     fu_dest_tag;
    logic [NUM_FU-1:0][ROB_IDX_W-1:0] fu_rob_idx;
    logic [NUM_FU-1:0]                fu_branch_taken;
    logic                             squash_valid;
    logic                             squash_thread;
    logic [NUM_CDB-1:0]                cdb_valid;
    logic [NUM_CDB-1:0][TAG_W-1:0]     cdb_tag;
    logic [NUM_CDB-1:0][DATA_W-1:0]    cdb_out;
    logic [NUM_CDB-1:0][ROB_IDX_W-1:0] cdb_rob_idx;
    logic [NUM_CDB-1:0]                cdb_branch_is_taken;
    modport master (
        output fu_valid, fu_result, fu_dest_tag, fu_rob_idx, fu_branch_taken, squash_valid, squash_thread,
        input  fu_ready, cdb_valid, cdb_tag, cdb_out, cdb_rob_idx, cdb_branch_is_taken
    );
    modport slave (
        input  fu_valid, fu_result, fu_dest_tag, fu_rob_idx, fu_branch_taken, squash_valid, squash_thread,
        output fu_ready, cdb_valid, cdb_tag, cdb_out, cdb_rob_idx, cdb_branch_is_taken
    );
endinterface

// File: rtl/rr_multi_grant.sv
// rr_multi_grant: circular scan from ptr handing the first M requesters one bus each.
module rr_multi_grant #(
    parameter int N = 6,
    parameter int M = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]         req,
    input  logic [IW-1:0]        ptr,
    output logic [N-1:0]         grant,
    output logic [M-1:0][IW-1:0] sel,
    output logic [M-1:0]         sel_valid,
    output logic [IW-1:0]        next_ptr
);
    always_comb begin
        int cnt;
        logic [IW-1:0] p;
        grant = '0;
        sel = '0;
        sel_valid = '0;
        next_ptr = ptr;
        cnt = 0;
        p = '0;
        for (int j = 0; j < N; j++) begin
            p = (int'(ptr) + j >= N) ? IW'(int'(ptr) + j - N) : IW'(int'(ptr) + j);
            if (req[p] && cnt < M) begin
                grant[p] = 1'b1;
                for (int k = 0; k < M; k++)
                    if (k == cnt) begin
                        sel[k] = p;
                        sel_valid[k] = 1'b1;
                    end
                // explicit wrap keeps non-power-of-two sizes in range
                next_ptr = (int'(p) == N - 1) ? '0 : p + IW'(1);
                cnt++;
            end
        end
    end
endmodule

// File: rtl/cdb_rr_arbiter.sv
// cdb_rr_arbiter: one-entry slot per FU channel, round-robin broadcast onto NUM_CDB buses,
// per-thread squash of held and incoming results.
module cdb_rr_arbiter import cdb_pkg::*; #(
    parameter int NUM_FU = 6,
    parameter int NUM_CDB = 2
) (
    input logic clock,
    input logic reset,
    cdb_rr_arbiter_if.slave bus
);
    localparam int IW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    cdb_pkt_t                 slot_pkt [NUM_FU];
    logic [NUM_FU-1:0]        slot_valid, kill_slot, kill_in, elig, grant, load;
    logic [IW-1:0]            rr_ptr, next_ptr;
    logic [NUM_CDB-1:0][IW-1:0] sel;
    logic [NUM_CDB-1:0]       sel_valid;

    assign elig = slot_valid & ~kill_slot;
    assign bus.fu_ready = ~slot_valid | grant | kill_slot;
    assign load = bus.fu_valid & bus.fu_ready & ~kill_in;

    rr_multi_grant #(.N(NUM_FU), .M(NUM_CDB)) u_grant (
        .req(elig), .ptr(rr_ptr), .grant(grant), .sel(sel), .sel_valid(sel_valid), .next_ptr(next_ptr)
    );

    always_comb begin
        kill_slot = '0;
        kill_in = '0;
        bus.cdb_valid = sel_valid;
        bus.cdb_tag = '0;
        bus.cdb_out = '0;
        bus.cdb_rob_idx = '0;
        bus.cdb_branch_is_taken = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            kill_slot[i] = slot_valid[i] && bus.squash_valid && slot_pkt[i].rob_idx[ROB_IDX_W-1] == bus.squash_thread;
            kill_in[i] = bus.squash_valid && bus.fu_rob_idx[i][ROB_IDX_W-1] == bus.squash_thread;
        end
        for (int k = 0; k < NUM_CDB; k++)
            if (sel_valid[k]) begin
                bus.cdb_tag[k] = slot_pkt[sel[k]].tag;
                bus.cdb_out[k] = slot_pkt[sel[k]].data;
                bus.cdb_rob_idx[k] = slot_pkt[sel[k]].rob_idx;
                bus.cdb_branch_is_taken[k] = slot_pkt[sel[k]].branch_taken;
            end
    end

    // a load wins over a same-cycle grant so a winning channel can stream every cycle
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            slot_valid <= '0;
            rr_ptr <= '0;
        end else begin
            slot_valid <= load | (slot_valid & ~grant & ~kill_slot);
            rr_ptr <= next_ptr;
        end

    always_ff @(posedge clock)
        for (int i = 0; i < NUM_FU; i++)
            if (load[i])
                slot_pkt[i] <= '{tag: bus.fu_dest_tag[i], data: bus.fu_result[i],
                                 rob_idx: bus.fu_rob_idx[i], branch_taken: bus.fu_branch_taken[i]};
endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// tb_cdb_rr_arbiter: directed vectors into a 6x2 and a 5x3 arbiter; expected broadcasts are
// queued at stimulus time and popped by a monitor on every falling edge.
module tb_cdb_rr_arbiter;
    import cdb_pkg::*;
    typedef struct {
        int                   bus;
        logic [TAG_W-1:0]     tag;
        logic [DATA_W-1:0]    data;
        logic [ROB_IDX_W-1:0] rob;
        logic                 taken;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    exp_t q6[$];
    exp_t q5[$];

    cdb_rr_arbiter_if #(.NUM_FU(6), .NUM_CDB(2)) b6();
    cdb_rr_arbiter_if #(.NUM_FU(5), .NUM_CDB(3)) b5();
    cdb_rr_arbiter #(.NUM_FU(6), .NUM_CDB(2)) dut6 (.clock(clock), .reset(reset), .bus(b6.slave));
    cdb_rr_arbiter #(.NUM_FU(5), .NUM_CDB(3)) dut5 (.clock(clock), .reset(reset), .bus(b5.slave));

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic mon(input int inst, input int k, input logic v, input logic [TAG_W-1:0] tag,
                       input logic [DATA_W-1:0] data, input logic [ROB_IDX_W-1:0] rob, input logic tk);
        exp_t e;
        string name;
        name = $sformatf("cdb%0d_bus%0d", inst, k);
        if (!v) begin
            chk({name, "_idle"}, {tag, data, rob, tk}, '0);
            return;
        end
        if ((inst == 6 && q6.size() == 0) || (inst == 5 && q5.size() == 0)) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got unexpected broadcast tag %0d, expected no broadcast", name, tag);
            return;
        end
        if (inst == 6) e = q6.pop_front();
        else e = q5.pop_front();
        chk(name, {4'(k), tag, data, rob, tk}, {4'(e.bus), e.tag, e.data, e.rob, e.taken});
    endtask

    always @(negedge clock)
        if (reset) begin
            for (int k = 0; k < 2; k++)
                mon(6, k, b6.cdb_valid[k], b6.cdb_tag[k], b6.cdb_out[k], b6.cdb_rob_idx[k], b6.cdb_branch_is_taken[k]);
            for (int k = 0; k < 3; k++)
                mon(5, k, b5.cdb_valid[k], b5.cdb_tag[k], b5.cdb_out[k], b5.cdb_rob_idx[k], b5.cdb_branch_is_taken[k]);
        end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input int inst, input int i, input int tag, input logic [DATA_W-1:0] data,
                       input logic [ROB_IDX_W-1:0] rob, input logic tk);
        if (inst == 6) begin
            b6.fu_valid[i] = 1'b1;
            b6.fu_dest_tag[i] = TAG_W'(tag);
            b6.fu_result[i] = data;
            b6.fu_rob_idx[i] = rob;
            b6.fu_branch_taken[i] = tk;
        end else begin
            b5.fu_valid[i] = 1'b1;
            b5.fu_dest_tag[i] = TAG_W'(tag);
            b5.fu_result[i] = data;
            b5.fu_rob_idx[i] = rob;
            b5.fu_branch_taken[i] = tk;
        end
    endtask

    task automatic push(input int inst, input int bus, input int tag, input logic [DATA_W-1:0] data,
                        input logic [ROB_IDX_W-1:0] rob, input logic tk);
        exp_t e;
        e.bus = bus;
        e.tag = TAG_W'(tag);
        e.data = data;
        e.rob = rob;
        e.taken = tk;
        if (inst == 6) q6.push_back(e);
        else q5.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("rst_cdb_valid6", b6.cdb_valid, 0);
        chk("rst_cdb_out6", b6.cdb_out, 0);
        chk("rst_ready6", b6.fu_ready, 6'h3f);
        chk("rst_ptr6", dut6.rr_ptr, 0);
        chk("rst_ready5", b5.fu_ready, 5'h1f);
        @(negedge clock);
        #2 reset = 1'b1;
        step();
    endtask

    initial begin
        b6.fu_valid = '0; b6.fu_result = '0; b6.fu_dest_tag = '0; b6.fu_rob_idx = '0; b6.fu_branch_taken = '0;
        b6.squash_valid = 1'b0; b6.squash_thread = 1'b0;
        b5.fu_valid = '0; b5.fu_result = '0; b5.fu_dest_tag = '0; b5.fu_rob_idx = '0; b5.fu_branch_taken = '0;
        b5.squash_valid = 1'b0; b5.squash_thread = 1'b0;
        do_reset();

        // two channels together land on bus0/bus1 in scan order
        drv(6, 0, 1, 5, 6'b000101, 1'b1);
        drv(6, 3, 2, 7, 6'd1, 1'b0);
        #1 chk("t1_ready_in", b6.fu_ready, 6'h3f);
        push(6, 0, 1, 5, 6'b000101, 1'b1);
        push(6, 1, 2, 7, 6'd1, 1'b0);
        step();
        b6.fu_valid = '0;
        chk("t1_ready_bcast", b6.fu_ready, 6'h3f);
        step();
        chk("t1_ptr", dut6.rr_ptr, 4);

        // all six at once drain two per cycle from pointer 0
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drv(6, i, 10 + i, 64'h100 + 64'(i), 6'(i), 1'b0);
            push(6, i % 2, 10 + i, 64'h100 + 64'(i), 6'(i), 1'b0);
        end
        #1 chk("t2_ready_in", b6.fu_ready, 6'h3f);
        step();
        b6.fu_valid = '0;
        chk("t2_ready_c1", b6.fu_ready, 6'b000011);
        step();
        chk("t2_ready_c2", b6.fu_ready, 6'b001111);
        step();
        chk("t2_ready_c3", b6.fu_ready, 6'h3f);
        step();
        chk("t2_ptr", dut6.rr_ptr, 0);

        // mem2 streams one result per cycle
        for (int j = 0; j < 4; j++) begin
            drv(6, 5, 40 + j, 64'(100 + j), 6'd7, 1'b0);
            push(6, 0, 40 + j, 64'(100 + j), 6'd7, 1'b0);
            #1 chk($sformatf("t3_ready_%0d", j), b6.fu_ready[5], 1'b1);
            step();
        end
        b6.fu_valid = '0;
        step();

        // thread-1 squash kills the held mult1 and an incoming mem1 result
        drv(6, 1, 50, 64'h55, 6'b000100, 1'b0);
        drv(6, 2, 51, 64'h66, 6'b100010, 1'b0);
        step();
        b6.fu_valid = '0;
        b6.squash_valid = 1'b1;
        b6.squash_thread = 1'b1;
        drv(6, 4, 52, 64'h77, 6'b100001, 1'b0);
        push(6, 0, 50, 64'h55, 6'b000100, 1'b0);
        #1 chk("t4_ready", b6.fu_ready, 6'h3f);
        step();
        b6.fu_valid = '0;
        b6.squash_valid = 1'b0;
        chk("t4_slots", dut6.slot_valid, 0);
        step();
        chk("t4_ptr", dut6.rr_ptr, 2);

        // reset with a slot still pending after a broadcast cycle
        drv(6, 0, 60, 64'h600, 6'd3, 1'b0);
        drv(6, 1, 61, 64'h610, 6'd3, 1'b0);
        drv(6, 2, 62, 64'h620, 6'd3, 1'b1);
        push(6, 0, 62, 64'h620, 6'd3, 1'b1);
        push(6, 1, 60, 64'h600, 6'd3, 1'b0);
        step();
        b6.fu_valid = '0;
        @(negedge clock);
        #1 chk("t5_valid_before", b6.cdb_valid, 2'b11);
        reset = 1'b0;
        #1;
        chk("t5_valid_reset", b6.cdb_valid, 0);
        chk("t5_ready_reset", b6.fu_ready, 6'h3f);
        chk("t5_ptr_reset", dut6.rr_ptr, 0);
        #2 reset = 1'b1;
        step();
        chk("t5_ready_after", b6.fu_ready, 6'h3f);

        // 5 channels on 3 buses: {0,1,2} then {3,4,0} with the pointer wrapping
        for (int i = 0; i < 5; i++) drv(5, i, 70 + i, 64'hA0 + 64'(i), 6'(i), 1'b0);
        push(5, 0, 70, 64'hA0, 6'd0, 1'b0);
        push(5, 1, 71, 64'hA1, 6'd1, 1'b0);
        push(5, 2, 72, 64'hA2, 6'd2, 1'b0);
        #1 chk("t6_ready_in", b5.fu_ready, 5'h1f);
        step();
        for (int i = 0; i < 3; i++) drv(5, i, 80 + i, 64'hB0 + 64'(i), 6'(i), 1'b0);
        push(5, 0, 73, 64'hA3, 6'd3, 1'b0);
        push(5, 1, 74, 64'hA4, 6'd4, 1'b0);
        push(5, 2, 80, 64'hB0, 6'd0, 1'b0);
        #1 chk("t6_ready_c1", b5.fu_ready, 5'b00111);
        step();
        b5.fu_valid = '0;
        push(5, 0, 81, 64'hB1, 6'd1, 1'b0);
        push(5, 1, 82, 64'hB2, 6'd2, 1'b0);
        #1 chk("t6_ready_c2", b5.fu_ready, 5'b11001);
        step();
        chk("t6_ptr_wrap", dut5.rr_ptr, 1);
        step();
        chk("t6_ptr_end", dut5.rr_ptr, 3);

        repeat (3) step();
        chk("q6_drained", q6.size(), 0);
        chk("q5_drained", q5.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
